// File: rtl/trap_arbiter.sv
// trap_arbiter: edge-detects, latches and presents trap sources to the sequencer by fixed priority
module trap_arbiter #(
  parameter int NSRC = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] trap_src,
  input  logic [NSRC-1:0] trap_mask,
  input  logic            trap_ack,
  input  logic            clear_ovf,
  output logic            trap,
  output logic [IDXW-1:0] trap_idx,
  output logic [NSRC-1:0] trap_pending,
  output logic            trap_overflow
);
  typedef enum logic [1:0] {IDLE, PRESENT, HOLDOFF} state_t;
  if (NSRC < 1 || NSRC > 16 || IDXW != (NSRC > 1 ? $clog2(NSRC) : 1)) begin : g_bad_params
    $error("trap_arbiter: NSRC must be 1..16 and IDXW must equal max(1, clog2(NSRC))");
  end
  state_t state, state_next;
  logic [NSRC-1:0] src_prev, rise, clr;
  logic [IDXW-1:0] low;
  assign rise = trap_src & ~src_prev & trap_mask;
  // lowest pending index wins; only the presented bit is cleared, and only on an accepted ack
  always_comb begin
    low = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (trap_pending[i]) low = IDXW'(i);
    clr = (state == PRESENT && trap_ack) ? NSRC'(1) << trap_idx : '0;
    state_next = state == IDLE    ? (|trap_pending ? PRESENT : IDLE) :
                 state == PRESENT ? (trap_ack ? HOLDOFF : PRESENT) : IDLE;
  end
  // state, registered trap level, pending latches (set beats clear) and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      trap          <= 1'b0;
      trap_idx      <= '0;
      trap_pending  <= '0;
      trap_overflow <= 1'b0;
      src_prev      <= '0;
    end else begin
      state         <= state_next;
      trap          <= state_next == PRESENT;
      trap_idx      <= (state == IDLE && |trap_pending) ? low : trap_idx;
      trap_pending  <= rise | (trap_pending & ~clr);
      trap_overflow <= |(rise & trap_pending & ~clr) | (trap_overflow & ~clear_ovf);
      src_prev      <= trap_src;
    end
  end
endmodule

// File: tb/tb_trap_arbiter.sv
// tb_trap_arbiter: directed scoreboard bench for trap_arbiter
module tb_trap_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] trap_src = '0;
  logic [3:0] trap_mask = 4'b1111;
  logic       trap_ack = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       trap;
  logic [1:0] trap_idx;
  logic [3:0] trap_pending;
  logic       trap_overflow;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  logic trap_d = 1'b0;

  trap_arbiter #(.NSRC(4), .IDXW(2)) dut (
    .clk(clk), .reset(reset), .trap_src(trap_src), .trap_mask(trap_mask),
    .trap_ack(trap_ack), .clear_ovf(clear_ovf), .trap(trap), .trap_idx(trap_idx),
    .trap_pending(trap_pending), .trap_overflow(trap_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_trap();
    int k = 0;
    while (!trap && k < 50) begin
      tick();
      k++;
    end
    chk("trap_wait", trap, 1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("trap_drop_after_ack", trap, 0);
  endtask

  // each new trap presentation must match the next expected index in the scoreboard
  always @(negedge clk) begin
    if (trap && !trap_d) begin
      if (exp_q.size() == 0) chk("unexpected_trap", 1, 0);
      else chk("presented_idx", trap_idx, exp_q.pop_front());
    end
    trap_d = trap;
  end

  initial begin
    tick(2);
    chk("rst_trap", trap, 0);
    chk("rst_idx", trap_idx, 0);
    chk("rst_pending", trap_pending, 0);
    chk("rst_ovf", trap_overflow, 0);
    reset = 1'b0;
    tick(2);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("idle_ack_ignored", trap, 0);
    trap_src = 4'b0100; exp_q.push_back(2);
    tick();
    trap_src = 4'b0000;
    chk("single_pending", trap_pending, 4'b0100);
    chk("single_trap_lat1", trap, 0);
    tick();
    chk("single_trap_lat2", trap, 1);
    tick(2);
    chk("single_hold_idx", trap_idx, 2);
    chk("single_hold_trap", trap, 1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("single_ack_trap", trap, 0);
    chk("single_ack_pending", trap_pending, 0);
    tick(2);
    trap_src = 4'b1010; exp_q.push_back(1); exp_q.push_back(3);
    tick();
    trap_src = 4'b0000;
    tick();
    chk("prio_first_idx", trap_idx, 1);
    chk("prio_pending", trap_pending, 4'b1010);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("prio_ack_drop", trap, 0);
    chk("prio_pending_after", trap_pending, 4'b1000);
    tick();
    chk("prio_holdoff_gap", trap, 0);
    tick();
    chk("prio_second_trap", trap, 1);
    chk("prio_second_idx", trap_idx, 3);
    ack_trap();
    tick(2);
    trap_src = 4'b0100; exp_q.push_back(2);
    tick();
    trap_src = 4'b0000;
    tick();
    trap_src = 4'b0001; exp_q.push_back(0);
    tick();
    trap_src = 4'b0000;
    tick(3);
    chk("nopreempt_idx", trap_idx, 2);
    chk("nopreempt_pending", trap_pending, 4'b0101);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("nopreempt_drop", trap, 0);
    tick();
    chk("nopreempt_gap", trap, 0);
    tick();
    chk("nopreempt_next_idx", trap_idx, 0);
    ack_trap();
    tick(2);
    trap_src = 4'b0100; exp_q.push_back(2);
    tick();
    trap_src = 4'b0000;
    tick();
    trap_src = 4'b0100;
    tick();
    trap_src = 4'b0000;
    chk("ovf_set", trap_overflow, 1);
    tick();
    chk("ovf_sticky", trap_overflow, 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", trap_overflow, 0);
    chk("ovf_still_presenting", trap, 1);
    trap_src = 4'b0100; trap_ack = 1'b1; exp_q.push_back(2);
    tick();
    trap_src = 4'b0000; trap_ack = 1'b0;
    chk("setclr_pending", trap_pending, 4'b0100);
    chk("setclr_no_ovf", trap_overflow, 0);
    chk("setclr_drop", trap, 0);
    ack_trap();
    tick(2);
    trap_src = 4'b0010; exp_q.push_back(1);
    ack_trap();
    tick(16);
    chk("level_no_retrap", trap, 0);
    chk("level_no_pending", trap_pending, 0);
    trap_src = 4'b0000;
    tick();
    trap_mask = 4'b1101;
    trap_src = 4'b0010;
    tick();
    trap_src = 4'b0000;
    tick(3);
    chk("masked_pending", trap_pending, 0);
    chk("masked_trap", trap, 0);
    trap_mask = 4'b1111;
    trap_src = 4'b0100; exp_q.push_back(2);
    tick();
    trap_src = 4'b0000; trap_mask = 4'b1011;
    tick();
    chk("unmask_pending_kept", trap_pending, 4'b0100);
    chk("unmask_trap_delivered", trap, 1);
    ack_trap();
    trap_mask = 4'b1111;
    tick(2);
    trap_src = 4'b1010; exp_q.push_back(1);
    tick();
    trap_src = 4'b1000;
    tick();
    chk("midrst_trap", trap, 1);
    chk("midrst_pending", trap_pending, 4'b1010);
    reset = 1'b1;
    tick();
    chk("midrst_trap_cleared", trap, 0);
    chk("midrst_pending_cleared", trap_pending, 0);
    chk("midrst_idx_cleared", trap_idx, 0);
    chk("midrst_ovf_cleared", trap_overflow, 0);
    reset = 1'b0; exp_q.push_back(3);
    tick();
    chk("postrst_pending", trap_pending, 4'b1000);
    chk("postrst_trap_lat1", trap, 0);
    tick();
    chk("postrst_trap", trap, 1);
    chk("postrst_idx", trap_idx, 3);
    ack_trap();
    trap_src = 4'b0000;
    tick(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/trap_arbiter.md
Name: trap_arbiter

Overview:
Parametrised trap controller that replaces the single pass-through boot trap. It collects NSRC trap sources and edge-detects and latches each one. A fixed-priority handshake then presents the sources to the microsequencer one at a time. The sequencer receives a registered trap level plus the winning source index and retires each trap with trap_ack.

Parameters:
NSRC, 4, number of trap sources; bit 0 has the highest priority; legal range 1..16.
IDXW, 2, width of trap_idx; must equal max(1, clog2(NSRC)); an elaboration-time check fails otherwise.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
trap_src  input  NSRC  raw trap requests; only rising edges are significant.
trap_mask  input  NSRC  1 = source enabled; gates latching only.
trap_ack  input  1  sequencer has taken the current trap; meaningful only while trap=1.
clear_ovf  input  1  clears trap_overflow.
trap  output  1  registered trap request to the sequencer.
trap_idx  output  IDXW  index of the trap being presented; stable while trap=1.
trap_pending  output  NSRC  latched, un-retired trap bits.
trap_overflow  output  1  sticky flag: a source edge arrived while its pending bit was already set.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - trap=0, trap_idx=0, trap_pending=0, trap_overflow=0.
  - src_prev=0, so a source already high when reset releases counts as a rising edge.
  - FSM goes to IDLE.
  - Reset mid-handshake abandons the trap; no ack is required afterwards.
- Edge detect:
  - rise[i] = trap_src[i] & ~src_prev[i] & trap_mask[i].
  - src_prev is registered every cycle, masked or not.
- Pending update each cycle: pending_next[i] = rise[i] | (pending[i] & ~clr[i]).
  - clr[i] is true only for the retiring index, in the cycle trap_ack is accepted.
  - Set beats clear: a rise on the retiring bit in the ack cycle leaves the bit set, and a second trap follows.
- Overflow:
  - trap_overflow is set when rise[i] & pending[i] & ~clr[i] for any i.
  - It is cleared by clear_ovf.
  - If set and clear happen in the same cycle, set wins.
- Masking:
  - Clearing a mask bit does not drop an already-pending bit.
  - A masked edge is lost and is not deferred.
- FSM:
  - IDLE: trap=0. If pending≠0, latch trap_idx = lowest set index of pending, then go to PRESENT.
  - PRESENT: trap=1 and trap_idx is held. On trap_ack, clear pending[trap_idx] and go to HOLDOFF.
  - HOLDOFF: trap=0 for exactly one cycle, then go to IDLE.
- Latency and ordering:
  - A rise at edge N sets pending at N+1 and asserts trap at N+2.
  - After an ack at edge A, trap drops at A+1. The next pending trap is asserted no earlier than A+3.
  - Arbitration happens only in IDLE. A higher-priority source arriving during PRESENT waits; the presented index is never pre-empted.
- trap_ack in IDLE or HOLDOFF is ignored and causes no state change.
- With NSRC=1 and mask=1, the block behaves as a latched boot trap with a handshake.

Test Plan:
- Reset then single edge: NSRC=4, mask=4'b1111, pulse trap_src[2] at edge 10 → pending=4'b0100 at 11, trap=1 and idx=2 at 12, held until ack; ack at 15 → trap=0 and pending=0 at 16.
- Priority: raise trap_src[3] and trap_src[1] in the same cycle → idx=1 is presented first; after its ack plus one HOLDOFF cycle, idx=3 is presented; each trap has exactly one cycle of trap=1 per ack.
- No pre-emption: while idx=2 is presented, raise trap_src[0] → idx stays 2 until ack, then idx=0 is presented ≥2 cycles later.
- Overflow and set-over-clear:
  - Second rise on src[2] while pending[2]=1 → trap_overflow=1 next cycle.
  - clear_ovf → 0.
  - Rise on src[2] in the same cycle as the ack of idx=2 → pending[2] stays 1 and trap re-asserts with idx=2.
- Masking and level: hold trap_src[1]=1 for 20 cycles → exactly one trap. With mask[1]=0, pulse src[1] → no pending and no trap. Clear mask[2] while pending[2]=1 → the trap is still delivered.
- Reset mid-operation: assert reset while trap=1 and pending=4'b1010 → next cycle all outputs are 0. If trap_src[3] is held high through reset, a trap for idx=3 appears 2 cycles after reset deasserts.
